// File: rtl/sliced_mux_stream.sv
// sliced_mux_stream: N_IN:1 stream multiplexer with a registered single-entry output stage.
// The DATA_W datapath is built from DATA_W/SLICE_W identical SLICE_W-wide N_IN:1 slice muxes,
// all driven by one shared one-hot decoded channel select.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   mode       0 = external select (sel), 1 = round-robin over valid inputs
//   sel        channel index used in mode 0
//   in_valid   per-channel valid
//   in_data    packed channel data, channel i at [i*DATA_W +: DATA_W]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds an item
//   out_data   registered data
//   out_sel    index of the channel that supplied out_data
//   out_ready  consumer accepts the held item
module sliced_mux_stream #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SLICE_W = 2,
    localparam int unsigned SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_IN-1:0]        in_valid,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic [N_IN-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready
);

    localparam int unsigned N_SLICES = DATA_W / SLICE_W;

    if (DATA_W % SLICE_W != 0) begin : g_bad_slice_w
        $error("sliced_mux_stream: DATA_W must be a multiple of SLICE_W");
    end

    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;
    logic [SEL_W-1:0]     out_sel_q;
    logic [SEL_W-1:0]     rr_ptr_q;

    logic                 can_load;
    logic                 hit;
    logic                 ext_hit;
    logic [SEL_W-1:0]     rr_ch;
    logic [SEL_W-1:0]     ch;
    logic [N_IN-1:0]      ch_oh;
    logic [DATA_W-1:0]    mux_data;

    assign can_load = !out_valid_q || out_ready;

    // Round-robin pick: first valid channel after rr_ptr, wrapping. The wrap pass (i <= rr_ptr)
    // runs first so any valid channel above rr_ptr overrides it; descending loops leave the
    // lowest matching index.
    always_comb begin
        rr_ch = '0;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (in_valid[i] && (SEL_W'(i) <= rr_ptr_q)) rr_ch = SEL_W'(i);
        end
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (in_valid[i] && (SEL_W'(i) > rr_ptr_q)) rr_ch = SEL_W'(i);
        end
    end

    // An out-of-range sel matches no channel, so it never hits.
    always_comb begin
        ext_hit = 1'b0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (sel == SEL_W'(i)) ext_hit = in_valid[i];
        end
    end

    assign ch  = mode ? rr_ch : sel;
    assign hit = mode ? |in_valid : ext_hit;

    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            ch_oh[i] = (ch == SEL_W'(i));
        end
    end

    // Identical narrow slice muxes sharing ch_oh; slice k carries bits [k*SLICE_W +: SLICE_W].
    for (genvar k = 0; k < int'(N_SLICES); k++) begin : g_slice
        logic [SLICE_W-1:0] slice_out;

        always_comb begin
            slice_out = '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                if (ch_oh[i]) slice_out = in_data[i*DATA_W + k*SLICE_W +: SLICE_W];
            end
        end

        assign mux_data[k*SLICE_W +: SLICE_W] = slice_out;
    end

    // Ready is withheld during reset so producers do not see a transfer that never lands.
    assign in_ready = (can_load && hit && !rst) ? ch_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SEL_W'(N_IN - 1);
        end else if (can_load) begin
            out_valid_q <= hit;
            if (hit) begin
                out_data_q <= mux_data;
                out_sel_q  <= ch;
                if (mode) rr_ptr_q <= ch;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
